// File: rtl/dca_matrix_lsu_rdata_unpacker.sv
// Unpacks packed memory rows (2^lsa-bit fields) into fixed-width, sign/zero-extended elements.
// Latency: 1 cycle through a 2-entry FIFO; unpacking is combinational from the head entry.
// Backpressure: mrow_ready is low while both entries are occupied, regardless of erow_ready.
module dca_matrix_lsu_rdata_unpacker #(
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_LSU_ELEMENT = 32,
    parameter int BW_TXN_INFO    = 8
) (
    input  logic                                     clk,
    input  logic                                     rstnn,
    input  logic                                     mrow_valid,
    output logic                                     mrow_ready,
    input  logic [32*MATRIX_NUM_COL-1:0]             mrow_data,
    input  logic [2:0]                               mrow_lsa,
    input  logic                                     mrow_is_signed,
    input  logic [BW_TXN_INFO-1:0]                   mrow_txn_info,
    output logic                                     erow_valid,
    input  logic                                     erow_ready,
    output logic [BW_LSU_ELEMENT*MATRIX_NUM_COL-1:0] erow_data,
    output logic [BW_TXN_INFO-1:0]                   erow_txn_info,
    input  logic                                     count_clear,
    output logic [15:0]                              row_count
);

    localparam int BW_ROW = 32 * MATRIX_NUM_COL;

    logic [BW_ROW-1:0]      data_q [2];
    logic [BW_ROW-1:0]      data_d [2];
    logic [2:0]             lsa_q  [2];
    logic [2:0]             lsa_d  [2];
    logic                   sgn_q  [2];
    logic                   sgn_d  [2];
    logic [BW_TXN_INFO-1:0] tag_q  [2];
    logic [BW_TXN_INFO-1:0] tag_d  [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [15:0]            row_count_q, row_count_d;

    logic push, pop;

    assign mrow_ready = (cnt_q < 2'd2);
    assign erow_valid = (cnt_q != 2'd0);
    assign push       = mrow_valid & mrow_ready;
    assign pop        = erow_valid & erow_ready;
    assign row_count  = row_count_q;

    always_comb begin
        data_d   = data_q;
        lsa_d    = lsa_q;
        sgn_d    = sgn_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            data_d[wr_ptr_q] = mrow_data;
            lsa_d[wr_ptr_q]  = mrow_lsa;
            sgn_d[wr_ptr_q]  = mrow_is_signed;
            tag_d[wr_ptr_q]  = mrow_txn_info;
        end
        // Clear wins over a concurrent pop.
        if (count_clear) begin
            row_count_d = 16'd0;
        end else begin
            row_count_d = row_count_q + {15'd0, pop};
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            for (int e = 0; e < 2; e++) begin
                data_q[e] <= '0;
                lsa_q[e]  <= '0;
                sgn_q[e]  <= 1'b0;
                tag_q[e]  <= '0;
            end
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            row_count_q <= 16'd0;
        end else begin
            data_q      <= data_d;
            lsa_q       <= lsa_d;
            sgn_q       <= sgn_d;
            tag_q       <= tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            row_count_q <= row_count_d;
        end
    end

    logic [BW_ROW-1:0] head_data;
    logic [2:0]        head_lsa;
    logic              head_sgn;
    logic [5:0]        w_bits;
    logic [31:0]       w_mask;
    logic [31:0]       sign_mask;
    logic [BW_LSU_ELEMENT*MATRIX_NUM_COL-1:0] unpacked;

    assign head_data = data_q[rd_ptr_q];
    assign head_sgn  = sgn_q[rd_ptr_q];
    assign head_lsa  = (lsa_q[rd_ptr_q] > 3'd5) ? 3'd5 : lsa_q[rd_ptr_q];

    always_comb begin
        w_bits    = 6'd32;
        w_mask    = 32'hFFFF_FFFF;
        sign_mask = 32'h8000_0000;
        case (head_lsa)
            3'd0: begin w_bits = 6'd1;  w_mask = 32'h0000_0001; sign_mask = 32'h0000_0001; end
            3'd1: begin w_bits = 6'd2;  w_mask = 32'h0000_0003; sign_mask = 32'h0000_0002; end
            3'd2: begin w_bits = 6'd4;  w_mask = 32'h0000_000F; sign_mask = 32'h0000_0008; end
            3'd3: begin w_bits = 6'd8;  w_mask = 32'h0000_00FF; sign_mask = 32'h0000_0080; end
            3'd4: begin w_bits = 6'd16; w_mask = 32'h0000_FFFF; sign_mask = 32'h0000_8000; end
            default: ;
        endcase
    end

    // Each field is extended to 32 bits first, then the low BW_LSU_ELEMENT bits are kept,
    // which covers both widening and truncation.
    always_comb begin
        logic [BW_ROW-1:0] shifted;
        logic [31:0]       field;
        logic [31:0]       ext;
        logic              sbit;
        unpacked = '0;
        shifted  = '0;
        field    = '0;
        ext      = '0;
        sbit     = 1'b0;
        for (int i = 0; i < MATRIX_NUM_COL; i++) begin
            shifted = head_data >> (w_bits * i);
            field   = shifted[31:0] & w_mask;
            sbit    = head_sgn && (head_lsa != 3'd0) && ((field & sign_mask) != 32'd0);
            ext     = field | ({32{sbit}} & ~w_mask);
            unpacked[BW_LSU_ELEMENT*i +: BW_LSU_ELEMENT] = ext[BW_LSU_ELEMENT-1:0];
        end
    end

    assign erow_data     = erow_valid ? unpacked : '0;
    assign erow_txn_info = erow_valid ? tag_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_dca_matrix_lsu_rdata_unpacker.sv
// Directed bench for the row unpacker: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key rows and corner cases.
module tb_dca_matrix_lsu_rdata_unpacker;

    localparam int NCOL = 4;
    localparam int BW   = 32;
    localparam int TW   = 8;
    localparam int ROWW = 32 * NCOL;
    localparam int OUTW = BW * NCOL;

    logic            clk = 1'b0;
    logic            rstnn;
    logic            mrow_valid;
    logic            mrow_ready;
    logic [ROWW-1:0] mrow_data;
    logic [2:0]      mrow_lsa;
    logic            mrow_is_signed;
    logic [TW-1:0]   mrow_txn_info;
    logic            erow_valid;
    logic            erow_ready;
    logic [OUTW-1:0] erow_data;
    logic [TW-1:0]   erow_txn_info;
    logic            count_clear;
    logic [15:0]     row_count;

    dca_matrix_lsu_rdata_unpacker #(
        .MATRIX_NUM_COL(NCOL), .BW_LSU_ELEMENT(BW), .BW_TXN_INFO(TW)
    ) dut (
        .clk(clk), .rstnn(rstnn),
        .mrow_valid(mrow_valid), .mrow_ready(mrow_ready), .mrow_data(mrow_data),
        .mrow_lsa(mrow_lsa), .mrow_is_signed(mrow_is_signed), .mrow_txn_info(mrow_txn_info),
        .erow_valid(erow_valid), .erow_ready(erow_ready), .erow_data(erow_data),
        .erow_txn_info(erow_txn_info), .count_clear(count_clear), .row_count(row_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROWW-1:0] data;
        logic [2:0]      lsa;
        logic            sgn;
        logic [TW-1:0]   tag;
    } row_t;

    row_t        mq[$];
    logic [15:0] mcount;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [OUTW-1:0] act, input logic [OUTW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Element i is the W-bit field at bit W*i, widened as a two's-complement number when signed.
    function automatic logic [OUTW-1:0] exp_row(input row_t r);
        int              w;
        logic [63:0]     f;
        logic [ROWW-1:0] sh;
        logic [OUTW-1:0] o;
        o = '0;
        w = (r.lsa > 3'd5) ? 32 : (1 << r.lsa);
        for (int i = 0; i < NCOL; i++) begin
            sh = r.data >> (w * i);
            f  = {32'd0, sh[31:0]} & ((64'd1 << w) - 64'd1);
            if (r.sgn && w > 1 && f[w-1]) f = f - (64'd1 << w);
            o[BW*i +: BW] = f[BW-1:0];
        end
        return o;
    endfunction

    always @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            mq.delete();
            mcount = 16'd0;
        end else begin
            bit   pu, po;
            row_t r;
            pu = mrow_valid && (mq.size() < 2);
            po = (mq.size() > 0) && erow_ready;
            if (po) void'(mq.pop_front());
            if (pu) begin
                r.data = mrow_data; r.lsa = mrow_lsa; r.sgn = mrow_is_signed; r.tag = mrow_txn_info;
                mq.push_back(r);
            end
            if (count_clear) mcount = 16'd0;
            else if (po)     mcount = mcount + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (rstnn) begin
            chk("mdl_mrow_ready", OUTW'(mrow_ready), OUTW'(mq.size() < 2));
            chk("mdl_erow_valid", OUTW'(erow_valid), OUTW'(mq.size() > 0));
            chk("mdl_erow_data", erow_data, (mq.size() > 0) ? exp_row(mq[0]) : '0);
            chk("mdl_erow_tag", OUTW'(erow_txn_info), (mq.size() > 0) ? OUTW'(mq[0].tag) : '0);
            chk("mdl_row_count", OUTW'(row_count), OUTW'(mcount));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_row(input logic [ROWW-1:0] d, input logic [2:0] l, input logic s, input logic [TW-1:0] t);
        mrow_data = d; mrow_lsa = l; mrow_is_signed = s; mrow_txn_info = t;
    endtask

    // Single-beat push into a FIFO known to have room.
    task automatic push_one(input logic [ROWW-1:0] d, input logic [2:0] l, input logic s, input logic [TW-1:0] t);
        set_row(d, l, s, t);
        mrow_valid = 1'b1;
        cyc();
        mrow_valid = 1'b0;
    endtask

    task automatic push_hold(input logic [ROWW-1:0] d, input logic [2:0] l, input logic s, input logic [TW-1:0] t);
        bit acc;
        int n;
        set_row(d, l, s, t);
        mrow_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = mrow_ready;
            cyc();
            n++;
        end
        if (!acc) chk("push_timeout", 1, 0);
        mrow_valid = 1'b0;
    endtask

    task automatic push_check(input string name, input logic [ROWW-1:0] d, input logic [2:0] l,
                              input logic s, input logic [TW-1:0] t, input logic [OUTW-1:0] exp);
        push_one(d, l, s, t);
        @(negedge clk);
        chk(name, erow_data, exp);
        chk({name, "_tag"}, OUTW'(erow_txn_info), OUTW'(t));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        rstnn = 1'b0; mrow_valid = 1'b0; erow_ready = 1'b0; count_clear = 1'b0;
        set_row('0, 3'd0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #2 rstnn = 1'b1;
        @(negedge clk);
        chk("rst_mrow_ready", OUTW'(mrow_ready), 1);
        chk("rst_erow_valid", OUTW'(erow_valid), 0);
        chk("rst_row_count", OUTW'(row_count), 0);
        chk("rst_erow_data", erow_data, 0);

        erow_ready = 1'b1;
        push_check("s8", 128'hFF01_7F80, 3'd3, 1'b1, 8'h5A,
                   128'hFFFFFFFF_00000001_0000007F_FFFFFF80);
        push_check("u8", 128'hFF01_7F80, 3'd3, 1'b0, 8'h5B,
                   128'h000000FF_00000001_0000007F_00000080);
        push_check("lsa0", 128'hB, 3'd0, 1'b1, 8'h01,
                   128'h00000001_00000000_00000001_00000001);
        push_check("s2", 128'h9C, 3'd1, 1'b1, 8'h02,
                   128'hFFFFFFFE_00000001_FFFFFFFF_00000000);
        push_check("s16_hi_ignored", 128'hDEADBEEF_DEADBEEF_7FFFFFFF_12348000, 3'd4, 1'b1, 8'h03,
                   128'h00007FFF_FFFFFFFF_00001234_FFFF8000);
        push_check("lsa6", 128'h44444444_83333333_22222222_91111111, 3'd6, 1'b1, 8'h77,
                   128'h44444444_83333333_22222222_91111111);
        push_check("lsa5", 128'h44444444_83333333_22222222_91111111, 3'd5, 1'b0, 8'h78,
                   128'h44444444_83333333_22222222_91111111);

        // Backpressure: third row must wait until an entry frees.
        cyc();
        count_clear = 1'b1;
        cyc();
        count_clear = 1'b0;
        erow_ready  = 1'b0;
        push_hold(128'hA, 3'd5, 1'b0, 8'hA0);
        push_hold(128'hB, 3'd5, 1'b0, 8'hB0);
        set_row(128'hC, 3'd5, 1'b0, 8'hC0);
        mrow_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_mrow_ready", OUTW'(mrow_ready), 0);
            chk("full_hold_data", erow_data, 128'hA);
            chk("full_hold_tag", OUTW'(erow_txn_info), 8'hA0);
        end
        erow_ready = 1'b1;
        push_hold(128'hC, 3'd5, 1'b0, 8'hC0);
        repeat (3) @(negedge clk);
        chk("bp_row_count", OUTW'(row_count), 3);

        // Simultaneous push/pop at occupancy 1 across pointer wrap.
        count_clear = 1'b1;
        cyc();
        count_clear = 1'b0;
        erow_ready  = 1'b0;
        push_one(128'h100, 3'd4, 1'b1, 8'h10);
        erow_ready = 1'b1;
        mrow_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_row(ROWW'(32'h8000 + k), 3'd4, 1'b1, TW'(8'h20 + k));
            cyc();
        end
        mrow_valid = 1'b0;
        @(negedge clk);
        chk("stream_count10", OUTW'(row_count), 10);
        chk("stream_occ1", OUTW'(erow_valid), 1);
        chk("stream_last_tag", OUTW'(erow_txn_info), 8'h29);
        cyc();
        @(negedge clk);
        chk("stream_count11", OUTW'(row_count), 11);
        chk("stream_empty", OUTW'(erow_valid), 0);

        // Counter wrap and clear-vs-increment.
        cyc();
        count_clear = 1'b1;
        cyc();
        count_clear = 1'b0;
        set_row(128'h0123_4567, 3'd2, 1'b1, 8'h33);
        mrow_valid = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 70000 && !hit; k++) begin
            @(negedge clk);
            if (row_count == 16'hFFFF) hit = 1'b1;
        end
        chk("wrap_reached_ffff", OUTW'(hit), 1);
        @(negedge clk);
        chk("wrap_to_zero", OUTW'(row_count), 0);
        @(posedge clk);
        #2 count_clear = 1'b1;
        cyc();
        count_clear = 1'b0;
        @(negedge clk);
        chk("clear_beats_pop", OUTW'(row_count), 0);
        mrow_valid = 1'b0;
        repeat (3) cyc();

        // Reset with two rows buffered.
        erow_ready = 1'b0;
        push_one(128'h11, 3'd3, 1'b0, 8'h11);
        push_one(128'h22, 3'd3, 1'b0, 8'h22);
        @(negedge clk);
        chk("pre_rst_full", OUTW'(mrow_ready), 0);
        cyc();
        rstnn = 1'b0;
        #1;
        chk("rst_mid_erow_valid", OUTW'(erow_valid), 0);
        chk("rst_mid_erow_data", erow_data, 0);
        repeat (2) @(posedge clk);
        #2 rstnn = 1'b1;
        erow_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_stale", OUTW'(erow_valid), 0);
            chk("post_rst_ready", OUTW'(mrow_ready), 1);
        end
        chk("post_rst_count", OUTW'(row_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dca_matrix_lsu_rdata_unpacker.md
DCA_MATRIX_LSU_RDATA_UNPACKER -- requirements
Module: dca_matrix_lsu_rdata_unpacker

Interface
REQ-001 SHALL have parameter MATRIX_NUM_COL, default 4: number of elements per row.
REQ-002 SHALL have parameter BW_LSU_ELEMENT, default 32: width of each unpacked element (max 32).
REQ-003 SHALL have parameter BW_TXN_INFO, default 8: width of the transaction tag carried with each row.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rstnn  input  1  asynchronous active-low reset.
REQ-007 mrow_valid  input  1  memory row beat valid.
REQ-008 mrow_ready  output  1  memory row beat accepted when valid&ready.
REQ-009 mrow_data  input  32*MATRIX_NUM_COL  packed memory row; element i occupies bits [W*i +: W], W = 2^lsa.
REQ-010 mrow_lsa  input  3  log2 of element bit width (0..5; 6,7 treated as 5).
REQ-011 mrow_is_signed  input  1  sign-extend elements when 1, zero-extend when 0.
REQ-012 mrow_txn_info  input  BW_TXN_INFO  tag travelling with the row.
REQ-013 erow_valid  output  1  unpacked element row valid.
REQ-014 erow_ready  input  1  consumer accepts when valid&ready.
REQ-015 erow_data  output  BW_LSU_ELEMENT*MATRIX_NUM_COL  element i at [BW_LSU_ELEMENT*i +: BW_LSU_ELEMENT].
REQ-016 erow_txn_info  output  BW_TXN_INFO  tag of the row at the head.
REQ-017 count_clear  input  1  synchronous clear of row_count.
REQ-018 row_count  output  16  number of element rows delivered since reset/clear.

Function
REQ-019 SHALL buffer accepted rows in a 2-entry FIFO storing data, lsa, is_signed, txn_info per entry.
REQ-020 SHALL drive mrow_ready = (occupancy < 2); no pass-through when full, even if erow_ready=1 that cycle.
REQ-021 SHALL push on mrow_valid&mrow_ready; pop on erow_valid&erow_ready; simultaneous push and pop leave occupancy unchanged.
REQ-022 SHALL drive erow_valid = (occupancy > 0); a row accepted in cycle N is visible on erow_* in cycle N+1 (latency 1).
REQ-023 SHALL unpack the head entry combinationally: element i = ext(data[W*i +: W]) to BW_LSU_ELEMENT, ext = sign when is_signed and W>1, zero otherwise; lsa=0 always zero-extended.
REQ-024 SHALL, when W > BW_LSU_ELEMENT, truncate to the low BW_LSU_ELEMENT bits.
REQ-025 SHALL ignore mrow_data bits above W*MATRIX_NUM_COL.
REQ-026 SHALL hold erow_data and erow_txn_info stable while erow_valid=1 and erow_ready=0.
REQ-027 SHALL drive erow_data and erow_txn_info to 0 when erow_valid=0.
REQ-028 SHALL keep FIFO order (first in, first out) across pointer wrap-around.
REQ-029 SHALL increment row_count by 1 per pop, wrapping 0xFFFF -> 0x0000.
REQ-030 SHALL give count_clear priority over an increment in the same cycle (result 0).

Reset
REQ-031 SHALL on rstnn=0 immediately empty the FIFO, reset pointers, row_count=0, erow_valid=0, mrow_ready=1 after release.
REQ-032 SHALL discard rows in flight when reset asserts mid-operation; no row is emitted after release until a new push.

Verification
REQ-033 Push lsa=3, signed, data bytes {0x80,0x7F,0x01,0xFF}, tag 0x5A -> next cycle erow_data elements {0xFFFFFF80,0x0000007F,0x00000001,0xFFFFFFFF}, tag 0x5A.
REQ-034 Same row with is_signed=0 -> elements {0x80,0x7F,0x01,0xFF}; lsa=0 data 0b1011 -> {1,1,0,1}; lsa=6 behaves as lsa=5.
REQ-035 Hold erow_ready=0, push 3 rows -> mrow_ready drops after 2 accepts, erow_* stable; release ready -> rows emitted in order, row_count=2 then 3 after third.
REQ-036 Occupancy 1, push and pop same cycle for 10 cycles -> occupancy stays 1, order preserved across pointer wrap, row_count +10.
REQ-037 row_count at 0xFFFF with pop -> 0x0000; pop with count_clear same cycle -> 0.
REQ-038 Assert rstnn low with 2 rows buffered -> erow_valid=0 immediately; after release, mrow_ready=1, no stale rows emitted.
